// File: rtl/cory_arbn_bandwidth.sv
// cory_arbn_bandwidth: K-input weighted bandwidth arbiter with per-channel carry-over budgets,
// emitting {source index, data} through an optional output queue.
module cory_arbn_bandwidth #(
   parameter int K = 4,
   parameter int N = 8,
   parameter int B = 8,
   parameter int L = 4,
   parameter int Q = 0,
   localparam int S = $clog2(K)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [K-1:0]   i_a_v,
   input  logic [K*N-1:0] i_a_d,
   input  logic [K*L-1:0] i_a_wt,
   input  logic [K*B-1:0] i_a_bw,
   output logic [K-1:0]   o_a_r,
   output logic           o_z_v,
   output logic [N-1:0]   o_z_d,
   output logic [S-1:0]   o_z_s,
   input  logic           i_z_r,
   output logic [S-1:0]   o_cur
);
   localparam int W = (B > L ? B : L) + 2;
   localparam logic [S:0] KW = (S+1)'(K);
   localparam logic [B:0] CMAX = '1;

   logic [S-1:0] cur, sel, nxt_cur;
   logic [S:0]   idx;
   logic         hit, int_v, int_r, acc, last;
   logic [B:0]   cnt [K];
   logic [B:0]   sat;
   logic [N-1:0] sel_d;
   logic [L-1:0] sel_wt;
   logic [B-1:0] sel_bw;
   logic [W-1:0] nxt, bud, rem;

   // Owner keeps the grant while valid; otherwise the first valid channel after it wins.
   always_comb begin
      sel = cur;
      hit = i_a_v[cur];
      idx = '0;
      for (int i = 1; i < K; i++) begin
         idx = {1'b0, cur} + (S+1)'(i);
         idx = idx >= KW ? idx - KW : idx;
         if (!hit && i_a_v[idx[S-1:0]]) begin
            sel = idx[S-1:0];
            hit = 1'b1;
         end
      end
   end

   assign int_v   = |i_a_v;
   assign acc     = int_v & int_r;
   assign sel_d   = i_a_d[sel*N +: N];
   assign sel_wt  = i_a_wt[sel*L +: L];
   assign sel_bw  = i_a_bw[sel*B +: B];
   assign nxt     = W'(cnt[sel]) + W'(sel_wt) + 1'b1;
   assign bud     = W'(sel_bw) + 1'b1;
   assign last    = nxt >= bud;
   assign rem     = nxt - bud;
   assign sat     = rem > W'(CMAX) ? CMAX : rem[B:0];
   assign nxt_cur = sel == S'(K-1) ? '0 : sel + 1'b1;
   assign o_a_r   = int_r ? i_a_v & (K'(1) << sel) : '0;
   assign o_cur   = cur;

   // Non-selected channels shed one beat of carried debt per accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur <= '0;
         for (int k = 0; k < K; k++) cnt[k] <= '0;
      end else if (int_v) begin
         cur <= acc && last ? nxt_cur : sel;
         if (acc)
            for (int k = 0; k < K; k++)
               cnt[k] <= S'(k) == sel ? (last ? sat : nxt[B:0]) : cnt[k] - (B+1)'(cnt[k] != '0);
      end
   end

   if (Q == 0) begin : g_pass
      assign int_r = i_z_r;
      assign o_z_v = int_v;
      assign o_z_d = sel_d;
      assign o_z_s = sel;
   end else begin : g_fifo
      localparam int P = Q > 1 ? $clog2(Q) : 1;
      localparam int C = $clog2(Q + 1);
      logic [S+N-1:0] mem [Q];
      logic [P-1:0]   wp, rp;
      logic [C-1:0]   num;
      logic           pop;
      assign pop   = o_z_v & i_z_r;
      assign int_r = num != C'(Q);
      assign o_z_v = num != '0;
      assign {o_z_s, o_z_d} = mem[rp];
      always_ff @(posedge clk) begin
         if (acc) mem[wp] <= {sel, sel_d};
      end
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            num <= '0;
         end else begin
            wp  <= acc ? (wp == P'(Q-1) ? '0 : wp + 1'b1) : wp;
            rp  <= pop ? (rp == P'(Q-1) ? '0 : rp + 1'b1) : rp;
            num <= num + C'(acc) - C'(pop);
         end
      end
   end
endmodule

// File: tb/tb_cory_arbn_bandwidth.sv
// tb_cory_arbn_bandwidth: vector tables, corner sequences and a randomized reference model
// for the weighted bandwidth arbiter (K=4/Q=0, K=3/Q=0 and K=4/Q=2 instances).
module tb_cory_arbn_bandwidth;
   logic        clk = 0, reset_n = 0, zr = 0;
   logic [3:0]  v = '0;
   logic [31:0] d = '0;
   logic [15:0] wt = '0;
   logic [31:0] bw = '0;
   logic [3:0]  o_a_r, q_a_r;
   logic [2:0]  t_a_r;
   logic        o_z_v, t_z_v, q_z_v;
   logic [7:0]  o_z_d, t_z_d, q_z_d;
   logic [1:0]  o_z_s, t_z_s, q_z_s, o_cur, t_cur, q_cur;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   cory_arbn_bandwidth #(.K(4), .Q(0)) dut (
      .clk(clk), .reset_n(reset_n), .i_a_v(v), .i_a_d(d), .i_a_wt(wt), .i_a_bw(bw),
      .o_a_r(o_a_r), .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_s(o_z_s), .i_z_r(zr), .o_cur(o_cur));
   cory_arbn_bandwidth #(.K(3), .Q(0)) dut3 (
      .clk(clk), .reset_n(reset_n), .i_a_v(v[2:0]), .i_a_d(d[23:0]), .i_a_wt(wt[11:0]),
      .i_a_bw(bw[23:0]), .o_a_r(t_a_r), .o_z_v(t_z_v), .o_z_d(t_z_d), .o_z_s(t_z_s),
      .i_z_r(zr), .o_cur(t_cur));
   cory_arbn_bandwidth #(.K(4), .Q(2)) dutq (
      .clk(clk), .reset_n(reset_n), .i_a_v(v), .i_a_d(d), .i_a_wt(wt), .i_a_bw(bw),
      .o_a_r(q_a_r), .o_z_v(q_z_v), .o_z_d(q_z_d), .o_z_s(q_z_s), .i_z_r(zr), .o_cur(q_cur));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1;
   endtask

   function automatic int msel(input logic [3:0] vv, input int c);
      for (int i = 0; i < 4; i++)
         if (vv[(c + i) % 4]) return (c + i) % 4;
      return c;
   endfunction

   typedef struct { logic zr; int s; int ar; int cur; } vec_t;
   vec_t tbl[18];
   int sq[10] = '{0, 0, 1, 2, 3, 3, 3, 3, 0, 0};
   int cs[10] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
   int mcnt[4];
   int mcur, s, ea, nx, b, nacc;
   logic [3:0] accd;

   initial begin
      for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, sq[i], 1 << sq[i], sq[i]};
      for (int i = 10; i < 15; i++) tbl[i] = '{1'b0, 1, 0, 1};
      tbl[15] = '{1'b1, 1, 2, 1};
      tbl[16] = '{1'b1, 2, 4, 2};
      tbl[17] = '{1'b1, 3, 8, 3};

      // reset state with idle inputs
      #1;
      chk("rst_cur", o_cur, 0);
      chk("rst_ar", o_a_r, 0);
      chk("rst_zv", o_z_v, 0);
      chk("rst_zs", o_z_s, 0);
      chk("rst_q_zv", q_z_v, 0);
      do_reset();

      // weighted rotation, then a 5-cycle output stall
      v = 4'hf;
      bw = {8'd3, 8'd0, 8'd0, 8'd1};
      for (int i = 0; i < 18; i++) begin
         zr = tbl[i].zr;
         #1;
         chk($sformatf("tbl%0d_s", i), o_z_s, tbl[i].s);
         chk($sformatf("tbl%0d_ar", i), o_a_r, tbl[i].ar);
         chk($sformatf("tbl%0d_cur", i), o_cur, tbl[i].cur);
         chk($sformatf("tbl%0d_zv", i), o_z_v, 1);
         @(negedge clk);
      end

      // single requester: back-to-back grants
      v = 4'b0100; bw = '0; zr = 1; nacc = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         #1;
         nacc += int'(o_a_r == 4'b0100);
         chk("solo_s", o_z_s, 2);
         chk("solo_cur", o_cur, i == 0 ? 0 : 3);
         @(negedge clk);
      end
      chk("solo_accepts", nacc, 10);

      // overshoot carry on channel 0
      v = 4'b0011; wt = 16'h0003; bw = {24'd0, 8'd5};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("carry%0d_s", i), o_z_s, cs[i]);
         chk($sformatf("carry%0d_ar", i), o_a_r, 1 << cs[i]);
         @(negedge clk);
      end

      // K=3 wrap: owner 2 rotates to 0
      v = 4'hf; wt = '0; bw = '0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("k3_%0d_s", i), t_z_s, i % 3);
         chk($sformatf("k3_%0d_cur", i), t_cur, i % 3);
         chk($sformatf("k3_%0d_ar", i), t_a_r, 1 << (i % 3));
         @(negedge clk);
      end

      // Q=2: fill, drain in order, then asynchronous reset mid-stream
      zr = 0;
      for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'hA0 + 8'(k);
      do_reset();
      #1; chk("q_ar0", q_a_r, 1); chk("q_zv0", q_z_v, 0);
      @(negedge clk);
      #1; chk("q_ar1", q_a_r, 2); chk("q_zv1", q_z_v, 1); chk("q_zs1", q_z_s, 0);
      @(negedge clk);
      #1; chk("q_full_ar", q_a_r, 0); chk("q_cur2", q_cur, 2);
      @(negedge clk);
      #1; chk("q_full_ar2", q_a_r, 0);
      @(negedge clk);
      zr = 1;
      #1; chk("q_pop0_s", q_z_s, 0); chk("q_pop0_d", q_z_d, 'hA0); chk("q_pop0_ar", q_a_r, 0);
      @(negedge clk);
      #1; chk("q_pop1_s", q_z_s, 1); chk("q_pop1_d", q_z_d, 'hA1); chk("q_ar5", q_a_r, 4);
      @(negedge clk);
      #1; chk("q_pop2_s", q_z_s, 2); chk("q_pop2_d", q_z_d, 'hA2);
      #2;
      reset_n = 0;
      #1; chk("q_rst_zv", q_z_v, 0); chk("q_rst_cur", q_cur, 0); chk("rst_mid_cur", o_cur, 0);
      @(negedge clk);
      reset_n = 1;

      // randomized traffic against the reference model
      v = '0; accd = '0; mcur = 0;
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 4; k++)
            if (!v[k] || accd[k]) begin
               v[k] = $urandom_range(0, 3) != 0;
               d[k*8 +: 8] = 8'($urandom);
               wt[k*4 +: 4] = 4'($urandom_range(0, 3));
               bw[k*8 +: 8] = 8'($urandom_range(0, 6));
            end
         zr = $urandom_range(0, 3) != 0;
         #1;
         s = msel(v, mcur);
         ea = (|v && zr) ? 1 << s : 0;
         chk("rnd_ar", o_a_r, ea);
         chk("rnd_zv", o_z_v, int'(|v));
         chk("rnd_zs", o_z_s, s);
         chk("rnd_zd", o_z_d, int'(d[s*8 +: 8]));
         chk("rnd_cur", o_cur, mcur);
         accd = 4'(ea);
         if (|v && zr) begin
            nx = mcnt[s] + int'(wt[s*4 +: 4]) + 1;
            b = int'(bw[s*8 +: 8]) + 1;
            for (int k = 0; k < 4; k++)
               if (k != s && mcnt[k] > 0) mcnt[k]--;
            if (nx >= b) begin
               mcnt[s] = nx - b > 511 ? 511 : nx - b;
               mcur = (s + 1) % 4;
            end else begin
               mcnt[s] = nx;
               mcur = s;
            end
         end else if (|v)
            mcur = s;
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
